// File: rtl/counter_share_pkg.sv
// counter_share_pkg: shared defaults and types for the time-shared counter block
//   NUM_CH_DEF / WIDTH_DEF : default channel count and count width
//   ch_idx_t               : channel index sized for NUM_CH_DEF channels
//   count_t                : one channel's count value at WIDTH_DEF bits
package counter_share_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int WIDTH_DEF  = 8;
  localparam int CH_IDX_W   = NUM_CH_DEF > 1 ? $clog2(NUM_CH_DEF) : 1;
  typedef logic [CH_IDX_W-1:0]  ch_idx_t;
  typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/counter_rr_arbiter.sv
// counter_rr_arbiter: combinational round-robin pick of the first eligible channel at or above ptr
//   eligible    in  NUM_CH  requesters allowed to win this cycle
//   ptr         in  IW      highest-priority channel this cycle
//   grant       out NUM_CH  one-hot winner (zero when nothing eligible)
//   grant_idx   out IW      winner index
//   grant_valid out 1       some channel won
module counter_rr_arbiter
  import counter_share_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int IW     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_valid
);
  logic [IW:0] s;
  // Walk offsets from the top down so the smallest offset from ptr is the last writer and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    s           = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = s >= (IW+1)'(NUM_CH) ? s - (IW+1)'(NUM_CH) : s;
      if (eligible[s[IW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = s[IW-1:0];
      end
    end
    grant = grant_valid ? NUM_CH'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: NUM_CH counters sharing one WIDTH-bit incrementer under round-robin arbitration
//   clk, reset  rising-edge clock, synchronous active-high reset
//   inc_req     per-channel level increment request, held until acked
//   clr         per-channel synchronous clear of the count
//   inc_ack     one-cycle pulse when a channel's increment commits
//   wrap        pulse on max->0 rollover; sticky saturation flag when COUNTER_SHARE_SAT_EN is defined
//   count       channel i at [i*WIDTH +: WIDTH], registered
//   busy        OR of eligible requests (combinational)
// Build option: COUNTER_SHARE_SAT_EN makes counts saturate at all-ones instead of wrapping.
module counter_share_ctrl
  import counter_share_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       inc_req,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       inc_ack,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic                    busy
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ack_q, ack_d, wrap_q, wrap_d, wrap_set;
  logic [NUM_CH-1:0] eligible, grant;
  logic [IW-1:0]     ptr_q, ptr_d, grant_idx;
  logic              grant_valid, at_max;
  logic [WIDTH-1:0]  cur, nxt;
  // Masking on the registered ack spaces increments of a held request two cycles apart.
  assign eligible = inc_req & ~clr & ~ack_q;
  assign busy     = |eligible;
  assign inc_ack  = ack_q;
  assign wrap     = wrap_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
  end
  counter_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );
  // The single shared incrementer: mux the winner's count, add one.
  assign cur    = cnt_q[grant_idx];
  assign at_max = &cur;
  always_comb begin
`ifdef COUNTER_SHARE_SAT_EN
    nxt = at_max ? cur : cur + 1'b1;
`else
    nxt = cur + 1'b1;
`endif
  end
  always_comb begin
    wrap_set = grant_valid && at_max ? grant : '0;
    ack_d    = grant;
    ptr_d    = !grant_valid ? ptr_q : grant_idx == IW'(NUM_CH - 1) ? '0 : grant_idx + 1'b1;
    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = clr[i] ? '0 : cnt_q[i];
    if (grant_valid) cnt_d[grant_idx] = nxt;
`ifdef COUNTER_SHARE_SAT_EN
    wrap_d = (wrap_q & ~clr) | wrap_set;
`else
    wrap_d = wrap_set;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '{default: '0};
      ack_q  <= '0;
      wrap_q <= '0;
      ptr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      wrap_q <= wrap_d;
      ptr_q  <= ptr_d;
    end
  end
endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb_counter_share_ctrl: directed bench with a reference model for counter_share_ctrl (honours COUNTER_SHARE_SAT_EN)
module tb_counter_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;
  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     inc_req, clr;
  logic [N-1:0]     inc_ack, wrap;
  logic [N*W-1:0]   count;
  logic             busy;
  int checks = 0;
  int errors = 0;
  int m_cnt [N];
  logic [N-1:0] m_ack, m_wrap;
  int m_ptr;

  counter_share_ctrl #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .inc_req(inc_req), .clr(clr),
    .inc_ack(inc_ack), .wrap(wrap), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(count[i*W +: W]);
  endfunction

  // One clock: drive, check busy, clock, advance the model, compare every output.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] cl);
    logic [N-1:0] elig, nack, nwf;
    int g;
    reset = r; inc_req = rq; clr = cl;
    #1;
    elig = rq & ~cl & ~m_ack;
    chk("busy", 32'(busy), 32'(|elig));
    @(posedge clk);
    #1;
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ack = '0; m_wrap = '0; m_ptr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      nack = '0; nwf = '0;
      for (int i = 0; i < N; i++) if (cl[i]) m_cnt[i] = 0;
      if (g >= 0) begin
        nack[g] = 1'b1;
        if (m_cnt[g] == MAXV) begin
          nwf[g] = 1'b1;
`ifdef COUNTER_SHARE_SAT_EN
          m_cnt[g] = MAXV;
`else
          m_cnt[g] = 0;
`endif
        end else m_cnt[g] = m_cnt[g] + 1;
        m_ptr = (g + 1) % N;
      end
`ifdef COUNTER_SHARE_SAT_EN
      m_wrap = (m_wrap & ~cl) | nwf;
`else
      m_wrap = nwf;
`endif
      m_ack = nack;
    end
    chk("inc_ack", 32'(inc_ack), 32'(m_ack));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    for (int i = 0; i < N; i++) chk($sformatf("count%0d", i), cnt_of(i), 32'(m_cnt[i]));
  endtask

  initial begin
    logic [N-1:0] r;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ack = '0; m_wrap = '0; m_ptr = 0;
    reset = 1'b1; inc_req = '0; clr = '0;
    @(posedge clk);
    #1;
    // 1: reset state
    step(1'b1, '0, '0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_ack", 32'(inc_ack), 32'd0);
    // 2: single pulse on channel 0
    step(1'b0, 4'b0001, '0);
    chk("t2_ack", 32'(inc_ack), 32'b0001);
    chk("t2_count0", cnt_of(0), 32'd1);
    step(1'b0, '0, '0);
    // 3: all four requesting from ptr=0, each dropped in its ack cycle
    step(1'b1, '0, '0);
    r = 4'b1111;
    for (int k = 0; k < N; k++) begin
      step(1'b0, r, '0);
      chk("t3_ack_order", 32'(inc_ack), 32'(1 << k));
      r = r & ~m_ack;
    end
    step(1'b0, '0, '0);
    for (int i = 0; i < N; i++) chk("t3_count", cnt_of(i), 32'd1);
    // 4: drive channel 2 to all-ones, then one more request
    step(1'b1, '0, '0);
    for (int k = 0; k < MAXV; k++) begin
      step(1'b0, 4'b0100, '0);
      step(1'b0, '0, '0);
    end
    chk("t4_preload", cnt_of(2), 32'hFF);
    step(1'b0, 4'b0100, '0);
    chk("t4_ack", 32'(inc_ack), 32'b0100);
    chk("t4_wrap", 32'(wrap), 32'b0100);
`ifdef COUNTER_SHARE_SAT_EN
    chk("t4_count2", cnt_of(2), 32'hFF);
`else
    chk("t4_count2", cnt_of(2), 32'h00);
`endif
    step(1'b0, '0, '0);
`ifdef COUNTER_SHARE_SAT_EN
    chk("t4_wrap_hold", 32'(wrap), 32'b0100);
`else
    chk("t4_wrap_hold", 32'(wrap), 32'b0000);
`endif
    step(1'b0, '0, 4'b0100);
    chk("t4_clr_wrap", 32'(wrap), 32'd0);
    chk("t4_clr_count", cnt_of(2), 32'd0);
    // 5: request+clear on channel 1 at count 5, channel 3 requests alongside
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0010, '0);
      step(1'b0, '0, '0);
    end
    chk("t5_pre", cnt_of(1), 32'd5);
    step(1'b0, 4'b1010, 4'b0010);
    chk("t5_count1", cnt_of(1), 32'd0);
    chk("t5_ack", 32'(inc_ack), 32'b1000);
    chk("t5_count3", cnt_of(3), 32'd1);
    step(1'b0, '0, '0);
    // 6: channel 2 held six cycles without dropping
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b0100, '0);
      chk("t6_ack_alt", 32'(inc_ack), (k % 2 == 0) ? 32'b0100 : 32'b0000);
    end
    chk("t6_count2", cnt_of(2), 32'd3);
    step(1'b1, 4'b1111, '0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_ack", 32'(inc_ack), 32'd0);
    step(1'b0, '0, '0);
    chk("t6_post_ack", 32'(inc_ack), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
